sic_alu_lock_arbiter: RTL and testbench
=======================================

Name: sic_alu_lock_arbiter

Overview:
- Shares one ALU among NUM_SICS sic_exec_alu instances by arbitrating their ALU lock requests (alu_rpl req / req_issue_id / release_lock).
- Grants a lock to the oldest requesting instruction by issue_id and holds it until the owner releases.
- Steers the owner's ALU request bus onto the shared ALU and signals its valid.
- Sits between the SIC array and the single shared ALU; the ALU answer is broadcast externally, and each SIC consumes it only while its grant is high.

Parameters:
- NUM_SICS, 4, number of requesting SICs (2..16).
- ID_WIDTH, 8, issue_id width; ids wrap modulo 2^ID_WIDTH.
- REQ_W, 72, width of one packed ALU request (op, a, b).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; drops any lock.
- rpl_req  in  NUM_SICS  per-SIC lock request level.
- rpl_issue_id  in  NUM_SICS*ID_WIDTH  per-SIC issue_id; SIC i occupies slice [i*ID_WIDTH +: ID_WIDTH].
- rpl_release  in  NUM_SICS  per-SIC one-cycle release pulse.
- alu_req_in  in  NUM_SICS*REQ_W  per-SIC ALU request buses.
- alu_grant  out  NUM_SICS  one-hot (or zero) grant, registered.
- alu_req_out  out  REQ_W  owner's request, or zero when idle.
- alu_req_valid  out  1  high while a lock is held.
- owner_id  out  $clog2(NUM_SICS)  index of the current owner; 0 when idle.

Behaviour:
- States: IDLE and LOCKED. Registers: owner, grant vector.
- Reset state: IDLE; alu_grant=0, alu_req_valid=0, alu_req_out=0, owner_id=0.
- Age compare: a is older than b iff bit [ID_WIDTH-1] of (a-b) mod 2^ID_WIDTH is 1. Ties go to the lower SIC index.
- Winner = oldest SIC in the eligible set.
- IDLE, with any rpl_req high:
  - Winner is chosen combinationally.
  - State goes to LOCKED and the winner's alu_grant bit is set on the next edge. Request-to-grant latency is 1 cycle.
- LOCKED:
  - alu_grant[owner] stays high.
  - alu_req_out = alu_req_in slice of owner, combinational mux.
  - alu_req_valid = 1.
- Release condition: rpl_release[owner]=1, OR rpl_req[owner]=0 (dropped request counts as an implicit release).
- Handoff on release (zero bubble):
  - Eligible set = requesters with rpl_req high, excluding the old owner.
  - If non-empty: the winner becomes owner on the next edge and its grant rises the cycle after the release.
  - If empty: go to IDLE and alu_grant goes to 0.
- The owner is never preempted by an older arriving request. Age order is applied only at arbitration points.
- Ignored events:
  - rpl_release from a non-owner.
  - rpl_release while IDLE.
  - rpl_req from the owner staying high after its release (that SIC is excluded for that one arbitration only).
- flush has priority over all other inputs: next state is IDLE with grants cleared. No arbitration happens in the flush cycle; requests still high afterwards re-arbitrate normally.
- Reset mid-lock: all outputs return to their reset values immediately (asynchronous).
- issue_id values of non-requesting SICs are don't-care.
- alu_grant is never multi-hot.

Optional Feature:
- Macro: SIC_ALU_ARB_STATS_EN.
- When defined, add outputs stat_grants (32-bit) and stat_wait_cycles (32-bit). Both reset to 0 and saturate at 0xFFFFFFFF.
  - stat_grants increments on each new lock grant, including handoffs.
  - stat_wait_cycles increments once per cycle in which at least one non-owner has rpl_req high.
  - Both clear on flush? No: they are unaffected by flush.
- When undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Single requester: SIC2 raises rpl_req with id 0x10 at cycle 0 -> alu_grant=4'b0100 and alu_req_valid=1 from cycle 1, alu_req_out = SIC2 bus. SIC2 releases at cycle 5 with no other requests -> grant 0 at cycle 6.
- Age order with wrap: SIC0 id 0x02 and SIC3 id 0xFE request together -> SIC3 granted (0xFE older than 0x02 modulo 256); owner_id=3.
- Tie: SIC1 and SIC2 both id 0x20 -> SIC1 granted.
- Handoff: SIC0 owns; SIC1 (id 5) and SIC2 (id 3) waiting; SIC0 pulses release at cycle t -> alu_grant=4'b0100 at t+1 with no idle cycle; SIC0 holding rpl_req high at t is not regranted.
- Implicit release and stale pulse: owner SIC1 drops rpl_req without a pulse -> lock freed next cycle. A release pulse from non-owner SIC3 changes nothing.
- Flush and reset: flush while SIC2 owns and SIC0 is requesting -> grant 0 for the next cycle, then SIC0 granted the cycle after. rst_n low mid-lock -> all outputs 0 asynchronously. With SIC_ALU_ARB_STATS_EN: 3 grants and 4 contended cycles -> stat_grants=3, stat_wait_cycles=4.

Source files
------------

// File: rtl/sic_alu_lock_arbiter.sv
// sic_alu_lock_arbiter
// ---------------------
// Shares one ALU among NUM_SICS sic_exec_alu instances. Each SIC asks for an
// ALU lock with a request level and its issue_id. The oldest requester
// (wrap-aware id compare, ties to the lower index) gets the lock. It keeps the
// lock until it pulses release or drops its request. On a release, the lock
// hands off to the next oldest requester with no idle cycle in between.
//
// Optional build macro: SIC_ALU_ARB_STATS_EN adds the grant and contention
// counters stat_grants and stat_wait_cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drops any lock; no arbitration happens in that cycle
//   rpl_req           per-SIC lock request level
//   rpl_issue_id      per-SIC issue_id, SIC i at [i*ID_WIDTH +: ID_WIDTH]
//   rpl_release       per-SIC one-cycle release pulse
//   alu_req_in        per-SIC packed ALU request, SIC i at [i*REQ_W +: REQ_W]
//   alu_grant         registered one-hot (or zero) grant vector
//   alu_req_out       owner's ALU request, zero when idle
//   alu_req_valid     high while a lock is held
//   owner_id          current owner index, zero when idle
//   stat_grants       (stats build) saturating count of new grants
//   stat_wait_cycles  (stats build) saturating count of contended cycles
module sic_alu_lock_arbiter #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8,
  parameter int REQ_W    = 72
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_SICS-1:0]           rpl_req,
  input  logic [NUM_SICS*ID_WIDTH-1:0]  rpl_issue_id,
  input  logic [NUM_SICS-1:0]           rpl_release,
  input  logic [NUM_SICS*REQ_W-1:0]     alu_req_in,
  output logic [NUM_SICS-1:0]           alu_grant,
  output logic [REQ_W-1:0]              alu_req_out,
  output logic                          alu_req_valid,
  output logic [$clog2(NUM_SICS)-1:0]   owner_id
`ifdef SIC_ALU_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_wait_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_SICS);

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_SICS-1:0] grant_q, grant_d;

  logic [NUM_SICS-1:0] owner_mask;
  logic [NUM_SICS-1:0] eligible;
  logic                owner_release;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] cand_id;
  logic [ID_WIDTH-1:0] age_diff;
  logic                new_grant;

  // One-hot of the current owner. It is all-zero in IDLE, so the same
  // eligible set serves both the idle arbitration and the handoff.
  always_comb begin
    owner_mask = '0;
    if (state_q == LOCKED) begin
      owner_mask[owner_q] = 1'b1;
    end
  end

  assign eligible      = rpl_req & ~owner_mask;
  assign owner_release = rpl_release[owner_q] | ~rpl_req[owner_q];

  // Linear oldest-first search. A candidate replaces the running winner only
  // when it is strictly older (MSB of the modular difference set). Equal ids
  // therefore keep the lower index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    cand_id   = '0;
    age_diff  = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      cand_id  = rpl_issue_id[i*ID_WIDTH +: ID_WIDTH];
      age_diff = cand_id - win_id;
      if (eligible[i] && (!win_found || age_diff[ID_WIDTH-1])) begin
        win_found = 1'b1;
        win_idx   = i[IDX_W-1:0];
        win_id    = cand_id;
      end
    end
  end

  // Next-state logic. Flush overrides everything. Age order is applied only
  // when idle or at a release, so a running owner is never preempted.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    new_grant = 1'b0;
    if (flush) begin
      state_d = IDLE;
      owner_d = '0;
      grant_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d          = LOCKED;
            owner_d          = win_idx;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            new_grant        = 1'b1;
          end
        end
        LOCKED: begin
          if (owner_release) begin
            if (win_found) begin
              owner_d          = win_idx;
              grant_d          = '0;
              grant_d[win_idx] = 1'b1;
              new_grant        = 1'b1;
            end else begin
              state_d = IDLE;
              owner_d = '0;
              grant_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          owner_d = '0;
          grant_d = '0;
        end
      endcase
    end
  end

  // Lock state, owner and registered grant vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  assign alu_grant     = grant_q;
  assign alu_req_valid = (state_q == LOCKED);
  assign owner_id      = owner_q;
  assign alu_req_out   = (state_q == LOCKED) ? alu_req_in[owner_q*REQ_W +: REQ_W]
                                             : '0;

`ifdef SIC_ALU_ARB_STATS_EN
  // Saturating counters. A flush leaves them unchanged. Only reset clears
  // them. A cycle counts as contended when any non-owner is requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants      <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (new_grant && (stat_grants != 32'hFFFF_FFFF)) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if ((|eligible) && (stat_wait_cycles != 32'hFFFF_FFFF)) begin
        stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// tb_sic_alu_lock_arbiter
// -----------------------
// Directed bench for sic_alu_lock_arbiter (4 SICs, 8-bit ids, 72-bit request
// buses). Each SIC drives a distinct request bus so the output mux can be
// identified. Inputs change 1ns after the rising edge, and outputs are
// checked at the same point.
module tb_sic_alu_lock_arbiter;

  localparam int NS = 4;
  localparam int IW = 8;
  localparam int RW = 72;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [NS-1:0]       rpl_req;
  logic [NS*IW-1:0]    rpl_issue_id;
  logic [NS-1:0]       rpl_release;
  logic [NS*RW-1:0]    alu_req_in;
  logic [NS-1:0]       alu_grant;
  logic [RW-1:0]       alu_req_out;
  logic                alu_req_valid;
  logic [1:0]          owner_id;
`ifdef SIC_ALU_ARB_STATS_EN
  logic [31:0]         stat_grants;
  logic [31:0]         stat_wait_cycles;
`endif

  int checkCount = 0;
  int errorCount = 0;

  sic_alu_lock_arbiter #(
    .NUM_SICS(NS),
    .ID_WIDTH(IW),
    .REQ_W(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .rpl_req(rpl_req),
    .rpl_issue_id(rpl_issue_id),
    .rpl_release(rpl_release),
    .alu_req_in(alu_req_in),
    .alu_grant(alu_grant),
    .alu_req_out(alu_req_out),
    .alu_req_valid(alu_req_valid),
    .owner_id(owner_id)
`ifdef SIC_ALU_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed per-SIC bus pattern: byte 0x10+i replicated nine times.
  function automatic logic [RW-1:0] busOf(input int i);
    logic [7:0] b;
    b = 8'h10 + i[7:0];
    return {9{b}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NS-1:0] req, input logic [NS-1:0] rel,
                               input logic fl);
    rpl_req     = req;
    rpl_release = rel;
    flush       = fl;
  endtask

  task automatic setId(input int i, input logic [IW-1:0] id);
    rpl_issue_id[i*IW +: IW] = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLock(input string tag, input logic [NS-1:0] g,
                           input logic v, input logic [RW-1:0] o, input logic [1:0] own);
    checkOutput({tag, ".grant"}, 128'(alu_grant), 128'(g));
    checkOutput({tag, ".valid"}, 128'(alu_req_valid), 128'(v));
    checkOutput({tag, ".out"}, 128'(alu_req_out), 128'(o));
    checkOutput({tag, ".owner"}, 128'(owner_id), 128'(own));
  endtask

  initial begin
    rst_n        = 1'b0;
    rpl_issue_id = '0;
    for (int i = 0; i < NS; i++) alu_req_in[i*RW +: RW] = busOf(i);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (3) tick();
    checkLock("reset", 4'b0000, 1'b0, '0, 2'd0);
    rst_n = 1'b1;
    tick();

    // Single requester: SIC2, grant one cycle later, released with no others.
    setId(2, 8'h10);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    checkLock("single", 4'b0100, 1'b1, busOf(2), 2'd2);
    repeat (3) tick();
    checkOutput("single.hold", 128'(alu_grant), 128'(4'b0100));
    // Release while still requesting: that SIC is excluded, so the lock goes idle.
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    tick();
    checkLock("single.rel", 4'b0000, 1'b0, '0, 2'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();

    // Wrap-aware age: 0xFE is older than 0x02.
    setId(0, 8'h02);
    setId(3, 8'hFE);
    applyStimulus(4'b1001, 4'b0000, 1'b0);
    tick();
    checkLock("wrap", 4'b1000, 1'b1, busOf(3), 2'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("wrap.drop", 128'(alu_grant), 128'(4'b0000));

    // Tie on equal ids goes to the lower index.
    setId(1, 8'h20);
    setId(2, 8'h20);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    tick();
    checkLock("tie", 4'b0010, 1'b1, busOf(1), 2'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("tie.drop", 128'(alu_grant), 128'(4'b0000));

    // Handoff: SIC0 owns. SIC1 (id 5) and SIC2 (id 3) arrive older but cannot preempt.
    setId(0, 8'h07);
    setId(1, 8'h05);
    setId(2, 8'h03);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    tick();
    checkOutput("hand.own0", 128'(alu_grant), 128'(4'b0001));
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    tick();
    checkOutput("hand.nopreempt", 128'(alu_grant), 128'(4'b0001));
    applyStimulus(4'b0111, 4'b0001, 1'b0);
    tick();
    checkLock("hand", 4'b0100, 1'b1, busOf(2), 2'd2);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    tick();
    checkOutput("hand.stay", 128'(alu_grant), 128'(4'b0100));

    // Implicit release: SIC2 drops its request and SIC1 takes over with no bubble.
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    tick();
    checkLock("implicit", 4'b0010, 1'b1, busOf(1), 2'd1);
    applyStimulus(4'b0010, 4'b1000, 1'b0);
    tick();
    checkOutput("stale.pulse", 128'(alu_grant), 128'(4'b0010));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("implicit.free", 128'(alu_grant), 128'(4'b0000));
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    tick();
    checkOutput("idle.pulse", 128'(alu_req_valid), 128'(1'b0));

    // Flush while SIC2 owns and SIC0 waits.
    setId(2, 8'h09);
    setId(0, 8'h01);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    checkOutput("flush.own2", 128'(alu_grant), 128'(4'b0100));
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    tick();
    checkLock("flush", 4'b0000, 1'b0, '0, 2'd0);
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    tick();
    checkLock("flush.rearb", 4'b0001, 1'b1, busOf(0), 2'd0);

    // Asynchronous reset in mid-lock, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkLock("async.rst", 4'b0000, 1'b0, '0, 2'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SIC_ALU_ARB_STATS_EN
    // Three grants and four contended cycles.
    setId(0, 8'h01);
    setId(1, 8'h02);
    setId(3, 8'h30);
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    tick();
    tick();
    applyStimulus(4'b0011, 4'b0001, 1'b0);
    tick();
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("stat.grants", 128'(stat_grants), 128'(32'd3));
    checkOutput("stat.wait", 128'(stat_wait_cycles), 128'(32'd4));
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
